// File: rtl/tilegen_pkg.sv
// Shared constants and helpers for the tile layer mixer.
package tilegen_pkg;
  localparam int DEF_COL_W = 8;
  localparam int DEF_DOT_W = 3;
  localparam int CLUT_W    = DEF_COL_W + DEF_DOT_W;

  localparam logic [2:0] WIN_BG = 3'd7;

  localparam logic [3:0] REG_ENABLE   = 4'h0;
  localparam logic [3:0] REG_BGCOL    = 4'h1;
  localparam logic [3:0] REG_PRI_BASE = 4'h2;

  // Bit i of a per-layer flag vector (enable, kill mask).
  function automatic logic layer_bit(input logic [7:0] vec, input int i);
    return vec[i[2:0]];
  endfunction

  // Packed ramp {..., 2, 1, 0} of w-bit fields, used as the reset priority set.
  function automatic logic [63:0] ramp_pri(input int n, input int w);
    logic [63:0] r;
    r = '0;
    for (int i = 0; i < n; i++) r = r | (64'(i) << (i * w));
    return r;
  endfunction
endpackage

// File: rtl/tile_pixel_serialiser.sv
// One tile layer: captures a 4-pixel group and presents one pixel per pix_en cycle.
module tile_pixel_serialiser #(
  parameter int               DOT_W           = 3,
  parameter int               COL_W           = 8,
  parameter int               PRI_W           = 3,
  parameter logic [DOT_W-1:0] TRANSPARENT_DOT = '1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  pix_en,
  input  logic                  load,
  input  logic                  flip,
  input  logic [3:0][DOT_W-1:0] gfx,
  input  logic [COL_W-1:0]      col,
  input  logic [PRI_W-1:0]      pri,
  output logic [DOT_W-1:0]      dot,
  output logic [COL_W-1:0]      cur_col,
  output logic [PRI_W-1:0]      cur_pri
);
  logic [3:0][DOT_W-1:0] pix_q;
  logic [COL_W-1:0]      col_q;
  logic [PRI_W-1:0]      pri_q;
  logic                  flip_q;
  logic [1:0]            idx_q;
  logic [1:0]            rem_q;  // pixels still to come after the current one
  logic [1:0]            first;

  assign first = flip ? 2'd3 : 2'd0;

  always_ff @(posedge clk) begin
    if (rst) begin
      pix_q  <= '0;
      col_q  <= '0;
      pri_q  <= '0;
      flip_q <= 1'b0;
      idx_q  <= '0;
      rem_q  <= '0;
    end else if (pix_en) begin
      if (load) begin
        pix_q  <= gfx;
        col_q  <= col;
        pri_q  <= pri;
        flip_q <= flip;
        idx_q  <= flip ? 2'd2 : 2'd1;
        rem_q  <= 2'd3;
      end else if (rem_q != 2'd0) begin
        idx_q <= flip_q ? idx_q - 2'd1 : idx_q + 2'd1;
        rem_q <= rem_q - 2'd1;
      end
    end
  end

  // A load presents its first pixel in the same cycle, overriding leftovers.
  always_comb begin
    dot     = TRANSPARENT_DOT;
    cur_col = col_q;
    cur_pri = pri_q;
    if (load) begin
      dot     = gfx[first];
      cur_col = col;
      cur_pri = pri;
    end else if (rem_q != 2'd0) begin
      dot = pix_q[idx_q];
    end
  end
endmodule

// File: rtl/tilegen_layer_mixer.sv
// N tile layers serialised and composited by priority into a palette PROM address.
module tilegen_layer_mixer import tilegen_pkg::*; #(
  parameter int                          NUM_LAYERS         = 4,
  parameter int                          PRI_W              = 3,
  parameter int                          COL_W              = DEF_COL_W,
  parameter int                          DOT_W              = DEF_DOT_W,
  parameter logic [DOT_W-1:0]            TRANSPARENT_DOT    = '1,
  parameter logic [NUM_LAYERS-1:0]       LAYER_DISABLE_MASK = '0,
  parameter logic [NUM_LAYERS*PRI_W-1:0] DEFAULT_PRIORITY   =
    (NUM_LAYERS*PRI_W)'(ramp_pri(NUM_LAYERS, PRI_W))
) (
  input  logic                                  CLK_6M,
  input  logic                                  rst,
  input  logic                                  pix_en,
  input  logic                                  FLIP,
  input  logic [NUM_LAYERS-1:0]                 load,
  input  logic [NUM_LAYERS-1:0][3:0][DOT_W-1:0] gfx,
  input  logic [NUM_LAYERS-1:0][COL_W-1:0]      attr_col,
  input  logic [NUM_LAYERS-1:0][PRI_W-1:0]      attr_pri,
  input  logic                                  cpu_we,
  input  logic [3:0]                            cpu_addr,
  input  logic [7:0]                            cpu_data,
  output logic [COL_W+DOT_W-1:0]                clut_addr,
  output logic                                  clut_valid,
  output logic [PRI_W-1:0]                      PRO,
  output logic [2:0]                            win_layer
);
  localparam int OUT_W = COL_W + DOT_W;

  logic [7:0]                       enable;
  logic [COL_W-1:0]                 bgcol;
  logic [NUM_LAYERS-1:0]            ovr_en;
  logic [NUM_LAYERS-1:0][PRI_W-1:0] ovr_pri;

  always_ff @(posedge CLK_6M) begin
    if (rst) begin
      enable  <= 8'hFF;
      bgcol   <= '0;
      ovr_en  <= '0;
      ovr_pri <= DEFAULT_PRIORITY;
    end else if (cpu_we) begin
      if (cpu_addr == REG_ENABLE) enable <= cpu_data;
      if (cpu_addr == REG_BGCOL)  bgcol  <= COL_W'(cpu_data);
      for (int i = 0; i < NUM_LAYERS; i++) begin
        if (cpu_addr == REG_PRI_BASE + 4'(i)) begin
          ovr_en[i]  <= cpu_data[7];
          ovr_pri[i] <= cpu_data[PRI_W-1:0];
        end
      end
    end
  end

  logic [NUM_LAYERS-1:0][DOT_W-1:0] cur_dot;
  logic [NUM_LAYERS-1:0][COL_W-1:0] cur_col;
  logic [NUM_LAYERS-1:0][PRI_W-1:0] cur_pri;

  for (genvar i = 0; i < NUM_LAYERS; i++) begin : g_layer
    tile_pixel_serialiser #(
      .DOT_W(DOT_W), .COL_W(COL_W), .PRI_W(PRI_W), .TRANSPARENT_DOT(TRANSPARENT_DOT)
    ) u_ser (
      .clk    (CLK_6M),
      .rst    (rst),
      .pix_en (pix_en),
      .load   (load[i]),
      .flip   (FLIP),
      .gfx    (gfx[i]),
      .col    (attr_col[i]),
      .pri    (attr_pri[i]),
      .dot    (cur_dot[i]),
      .cur_col(cur_col[i]),
      .cur_pri(cur_pri[i])
    );
  end

  // Stage 1: per-layer pixel with effective priority and opacity resolved.
  logic [NUM_LAYERS-1:0]            s1_opq;
  logic [NUM_LAYERS-1:0][DOT_W-1:0] s1_dot;
  logic [NUM_LAYERS-1:0][COL_W-1:0] s1_col;
  logic [NUM_LAYERS-1:0][PRI_W-1:0] s1_pri;
  logic [2:1]                       vld_pipe;

  always_ff @(posedge CLK_6M) begin
    if (rst) begin
      s1_opq <= '0;
      s1_dot <= '0;
      s1_col <= '0;
      s1_pri <= '0;
    end else if (pix_en) begin
      for (int i = 0; i < NUM_LAYERS; i++) begin
        s1_dot[i] <= cur_dot[i];
        s1_col[i] <= cur_col[i];
        s1_pri[i] <= ovr_en[i] ? ovr_pri[i] : cur_pri[i];
        s1_opq[i] <= (cur_dot[i] != TRANSPARENT_DOT) && layer_bit(enable, i) &&
                     !layer_bit(8'(LAYER_DISABLE_MASK), i);
      end
    end
  end

  // Ascending scan with >= so equal priorities resolve to the higher index.
  logic             win_found;
  logic [2:0]       win_idx;
  logic [PRI_W-1:0] win_pri;
  logic [OUT_W-1:0] win_addr;

  always_comb begin
    win_found = 1'b0;
    win_idx   = WIN_BG;
    win_pri   = '0;
    win_addr  = {bgcol, TRANSPARENT_DOT};
    for (int i = 0; i < NUM_LAYERS; i++) begin
      if (s1_opq[i] && (!win_found || s1_pri[i] >= win_pri)) begin
        win_found = 1'b1;
        win_idx   = 3'(i);
        win_pri   = s1_pri[i];
        win_addr  = {s1_col[i], s1_dot[i]};
      end
    end
  end

  always_ff @(posedge CLK_6M) begin
    if (rst) begin
      clut_addr <= '0;
      PRO       <= '0;
      win_layer <= WIN_BG;
      vld_pipe  <= '0;
    end else begin
      if (pix_en) begin
        clut_addr   <= win_addr;
        PRO         <= win_pri;
        win_layer   <= win_idx;
        vld_pipe[1] <= 1'b1;
      end
      vld_pipe[2] <= pix_en & vld_pipe[1];
    end
  end

  assign clut_valid = vld_pipe[2];
endmodule

// File: tb/tb_tilegen_layer_mixer.sv
// Scenario tasks plus a randomized run against a pixel-queue reference model.
module tb_tilegen_layer_mixer;
  localparam int NL = 4;

  logic            clk = 1'b0;
  logic            rst, pix_en, flip, cpu_we;
  logic [NL-1:0]   load;
  logic [NL*12-1:0] gfx;
  logic [NL*8-1:0] attr_col;
  logic [NL*3-1:0] attr_pri;
  logic [3:0]      cpu_addr;
  logic [7:0]      cpu_data;
  logic [10:0]     clut_addr;
  logic            clut_valid;
  logic [2:0]      pro, win_layer;
  logic [17:0]     obs;

  int n_checks = 0;
  int n_errors = 0;

  assign obs = {clut_valid, clut_addr, pro, win_layer};

  tilegen_layer_mixer dut (
    .CLK_6M(clk), .rst(rst), .pix_en(pix_en), .FLIP(flip), .load(load), .gfx(gfx),
    .attr_col(attr_col), .attr_pri(attr_pri), .cpu_we(cpu_we), .cpu_addr(cpu_addr),
    .cpu_data(cpu_data), .clut_addr(clut_addr), .clut_valid(clut_valid), .PRO(pro),
    .win_layer(win_layer)
  );

  always #5 clk = ~clk;

  // Reference model: register file, per-layer pending pixel list, one-cycle snapshot.
  logic [7:0] m_en, m_bg;
  logic       m_oen[NL];
  logic [2:0] m_opri[NL];
  logic [2:0] grp[NL][4];
  int         rem[NL], pos[NL];
  logic [7:0] g_col[NL];
  logic [2:0] g_pri[NL];
  logic       s_opq[NL];
  logic [2:0] s_dot[NL], s_pri[NL];
  logic [7:0] s_col[NL];
  logic       s_full;
  logic [17:0] exp_b;

  task automatic model_edge();
    int best;
    logic [2:0] d;
    if (rst) begin
      m_en = 8'hFF; m_bg = 8'h00; s_full = 1'b0;
      for (int i = 0; i < NL; i++) begin
        m_oen[i] = 1'b0; rem[i] = 0; s_opq[i] = 1'b0;
      end
      exp_b = {1'b0, 11'h000, 3'd0, 3'd7};
      return;
    end
    if (pix_en) begin
      best = -1;
      for (int p = 7; p >= 0; p--)
        for (int i = NL-1; i >= 0; i--)
          if (best < 0 && s_opq[i] && int'(s_pri[i]) == p) best = i;
      if (best < 0) exp_b = {s_full, m_bg, 3'd7, 3'd0, 3'd7};
      else exp_b = {s_full, s_col[best], s_dot[best], s_pri[best], 3'(best)};
      for (int i = 0; i < NL; i++) begin
        if (load[i]) begin
          for (int k = 0; k < 4; k++) grp[i][k] = gfx[(i*4 + (flip ? 3-k : k))*3 +: 3];
          g_col[i] = attr_col[i*8 +: 8]; g_pri[i] = attr_pri[i*3 +: 3];
          rem[i] = 4; pos[i] = 0;
        end
        d = 3'd7;
        if (rem[i] > 0) begin
          d = grp[i][pos[i]]; pos[i]++; rem[i]--;
        end
        s_dot[i] = d; s_col[i] = g_col[i];
        s_pri[i] = m_oen[i] ? m_opri[i] : g_pri[i];
        s_opq[i] = (d != 3'd7) && m_en[i];
      end
      s_full = 1'b1;
    end else begin
      exp_b[17] = 1'b0;
    end
    if (cpu_we) begin
      if (cpu_addr == 4'h0) m_en = cpu_data;
      else if (cpu_addr == 4'h1) m_bg = cpu_data;
      else if (cpu_addr >= 4'h2 && cpu_addr < 4'(2 + NL)) begin
        m_oen[cpu_addr - 4'h2]  = cpu_data[7];
        m_opri[cpu_addr - 4'h2] = cpu_data[2:0];
      end
    end
  endtask

  task automatic tick();
    @(posedge clk);
    model_edge();
    #1;
    load = '0;
    cpu_we = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) tick();
  endtask

  task automatic set_layer(input int i, input logic [2:0] p0, p1, p2, p3,
                           input logic [7:0] col, input logic [2:0] pri);
    gfx[i*12 +: 12]   = {p3, p2, p1, p0};
    attr_col[i*8 +: 8] = col;
    attr_pri[i*3 +: 3] = pri;
  endtask

  task automatic cpu_write(input logic [3:0] a, input logic [7:0] d);
    cpu_we = 1'b1; cpu_addr = a; cpu_data = d;
    tick();
  endtask

  task automatic test_reset();
    rst = 1'b1; pix_en = 1'b0;
    idle(2);
    rst = 1'b0;
    n_checks++;
    if (obs !== {1'b0, 11'h000, 3'd0, 3'd7}) begin
      n_errors++; $display("FAIL reset_state: got %h expected %h", obs, {1'b0, 11'h000, 3'd0, 3'd7});
    end
    pix_en = 1'b1;
    tick();
    n_checks++;
    if (clut_valid !== 1'b0) begin
      n_errors++; $display("FAIL reset_valid_c1: got %b expected 0", clut_valid);
    end
    tick();
    n_checks++;
    if (obs !== {1'b1, 11'h007, 3'd0, 3'd7}) begin
      n_errors++; $display("FAIL reset_bg: got %h expected %h", obs, {1'b1, 11'h007, 3'd0, 3'd7});
    end
  endtask

  task automatic test_single_layer();
    logic [17:0] fwd[5], rev[5];
    fwd = '{{1'b1, 11'h091, 3'd2, 3'd0}, {1'b1, 11'h092, 3'd2, 3'd0}, {1'b1, 11'h093, 3'd2, 3'd0},
            {1'b1, 11'h094, 3'd2, 3'd0}, {1'b1, 11'h007, 3'd0, 3'd7}};
    rev = '{fwd[3], fwd[2], fwd[1], fwd[0], fwd[4]};
    set_layer(0, 3'd1, 3'd2, 3'd3, 3'd4, 8'h12, 3'd2);
    flip = 1'b0; load[0] = 1'b1;
    tick();
    for (int k = 0; k < 5; k++) begin
      tick();
      n_checks++;
      if (obs !== fwd[k]) begin
        n_errors++; $display("FAIL single_fwd[%0d]: got %h expected %h", k, obs, fwd[k]);
      end
    end
    flip = 1'b1; load[0] = 1'b1;
    tick();
    flip = 1'b0;  // direction must stay as captured at load
    for (int k = 0; k < 5; k++) begin
      tick();
      n_checks++;
      if (obs !== rev[k]) begin
        n_errors++; $display("FAIL single_flip[%0d]: got %h expected %h", k, obs, rev[k]);
      end
    end
  endtask

  task automatic test_priority();
    set_layer(1, 3'd1, 3'd1, 3'd1, 3'd1, 8'h20, 3'd5);
    set_layer(3, 3'd2, 3'd2, 3'd2, 3'd2, 8'h30, 3'd5);
    load = 4'b1010;
    tick();
    tick();
    n_checks++;
    if (obs !== {1'b1, 11'h182, 3'd5, 3'd3}) begin
      n_errors++; $display("FAIL prio_tie: got %h expected %h", obs, {1'b1, 11'h182, 3'd5, 3'd3});
    end
    cpu_write(4'h3, 8'h86);
    tick();
    tick();
    n_checks++;
    if (obs !== {1'b1, 11'h101, 3'd6, 3'd1}) begin
      n_errors++; $display("FAIL prio_override: got %h expected %h", obs, {1'b1, 11'h101, 3'd6, 3'd1});
    end
    cpu_write(4'h3, 8'h00);
    idle(3);
  endtask

  task automatic test_enable_bg();
    cpu_write(4'h0, 8'hF7);
    set_layer(3, 3'd3, 3'd3, 3'd3, 3'd3, 8'h30, 3'd0);
    load[3] = 1'b1;
    tick();
    tick();
    n_checks++;
    if (obs !== {1'b1, 11'h007, 3'd0, 3'd7}) begin
      n_errors++; $display("FAIL disabled_layer: got %h expected %h", obs, {1'b1, 11'h007, 3'd0, 3'd7});
    end
    cpu_write(4'h1, 8'hA5);
    tick();
    n_checks++;
    if (obs !== {1'b1, 11'h52F, 3'd0, 3'd7}) begin
      n_errors++; $display("FAIL bgcol: got %h expected %h", obs, {1'b1, 11'h52F, 3'd0, 3'd7});
    end
    cpu_write(4'h0, 8'hFF);
    cpu_write(4'h1, 8'h00);
    idle(4);
  endtask

  task automatic test_back_to_back();
    logic [17:0] seq[7];
    seq = '{{1'b1, 11'h201, 3'd1, 3'd2}, {1'b1, 11'h202, 3'd1, 3'd2}, {1'b1, 11'h20D, 3'd1, 3'd2},
            {1'b1, 11'h20E, 3'd1, 3'd2}, {1'b1, 11'h208, 3'd1, 3'd2}, {1'b1, 11'h209, 3'd1, 3'd2},
            {1'b1, 11'h007, 3'd0, 3'd7}};
    set_layer(2, 3'd1, 3'd2, 3'd3, 3'd4, 8'h40, 3'd1);
    load[2] = 1'b1;
    tick();
    for (int k = 0; k < 7; k++) begin
      if (k == 1) begin
        set_layer(2, 3'd5, 3'd6, 3'd0, 3'd1, 8'h41, 3'd1);
        load[2] = 1'b1;
      end
      tick();
      n_checks++;
      if (obs !== seq[k]) begin
        n_errors++; $display("FAIL reload[%0d]: got %h expected %h", k, obs, seq[k]);
      end
    end
    set_layer(2, 3'd1, 3'd2, 3'd3, 3'd4, 8'h40, 3'd1);
    load[2] = 1'b1;
    tick();
    tick();
    pix_en = 1'b0;
    for (int k = 0; k < 3; k++) begin
      tick();
      n_checks++;
      if (obs !== {1'b0, 11'h201, 3'd1, 3'd2}) begin
        n_errors++; $display("FAIL stall[%0d]: got %h expected %h", k, obs, {1'b0, 11'h201, 3'd1, 3'd2});
      end
    end
    pix_en = 1'b1;
    tick();
    n_checks++;
    if (obs !== {1'b1, 11'h202, 3'd1, 3'd2}) begin
      n_errors++; $display("FAIL stall_resume: got %h expected %h", obs, {1'b1, 11'h202, 3'd1, 3'd2});
    end
    idle(4);
  endtask

  task automatic test_reset_mid();
    set_layer(0, 3'd1, 3'd2, 3'd3, 3'd4, 8'h12, 3'd2);
    load[0] = 1'b1;
    tick();
    tick();
    rst = 1'b1; cpu_we = 1'b1; cpu_addr = 4'h0; cpu_data = 8'h00;
    tick();
    rst = 1'b0;
    n_checks++;
    if (obs !== {1'b0, 11'h000, 3'd0, 3'd7}) begin
      n_errors++; $display("FAIL midreset_state: got %h expected %h", obs, {1'b0, 11'h000, 3'd0, 3'd7});
    end
    load[0] = 1'b1;
    tick();
    n_checks++;
    if (clut_valid !== 1'b0) begin
      n_errors++; $display("FAIL midreset_valid: got %b expected 0", clut_valid);
    end
    tick();
    n_checks++;
    if (obs !== {1'b1, 11'h091, 3'd2, 3'd0}) begin
      n_errors++; $display("FAIL midreset_enable: got %h expected %h", obs, {1'b1, 11'h091, 3'd2, 3'd0});
    end
    idle(4);
  endtask

  task automatic test_random();
    for (int c = 0; c < 400; c++) begin
      rst      = ($urandom_range(0, 99) == 0);
      pix_en   = ($urandom_range(0, 7) != 0);
      flip     = 1'($urandom());
      load     = NL'($urandom()) & NL'($urandom());
      gfx      = 48'({$urandom(), $urandom()});
      attr_col = $urandom();
      attr_pri = 12'($urandom());
      cpu_we   = ($urandom_range(0, 7) == 0);
      cpu_addr = 4'($urandom_range(0, 8));
      cpu_data = 8'($urandom());
      if (cpu_addr == 4'h0) cpu_data = cpu_data | 8'h0A;  // keep some layers alive
      tick();
      n_checks++;
      if (obs !== exp_b) begin
        n_errors++; $display("FAIL random[%0d]: got %h expected %h", c, obs, exp_b);
      end
    end
    rst = 1'b0;
  endtask

  initial begin
    rst = 1'b1; pix_en = 1'b0; flip = 1'b0; load = '0; gfx = '0;
    attr_col = '0; attr_pri = '0; cpu_we = 1'b0; cpu_addr = '0; cpu_data = '0;
    test_reset();
    test_single_layer();
    test_priority();
    test_enable_bg();
    test_back_to_back();
    test_reset_mid();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule

// File: doc/tilegen_layer_mixer.md
Name: tilegen_layer_mixer

Overview:
- Parametrised successor to the fixed two-chip, four-layer tile path: NUM_LAYERS tile layers, each with a 4-pixel serialiser, feed one registered priority compositor.
- Output is the tile-palette PROM address {colour, dot}, with a CPU-programmable background colour, runtime layer enables and per-layer priority overrides.
- Sits between the tile ROM/address generators and the tile CLUT. Replaces the chained CUS43 PR/CL/DT daisy-chain with a single N-way compare.

Parameters:
- NUM_LAYERS, 4, number of tile layers (1..8).
- PRI_W, 3, priority width.
- COL_W, 8, colour/palette-bank width.
- DOT_W, 3, bits per pixel.
- TRANSPARENT_DOT, {DOT_W{1'b1}}, dot value treated as transparent.
- LAYER_DISABLE_MASK, 0, static per-layer kill mask; bit i=1 disables layer i permanently.
- DEFAULT_PRIORITY, {NUM_LAYERS{PRI_W'(i)}} packed, reset priority of layer i (layer i = i).

Ports:
- CLK_6M  in  1  pixel clock; the only clock.
- rst  in  1  synchronous, active-high reset.
- pix_en  in  1  pixel advance strobe; all shifting and pipeline stages advance only when high.
- FLIP  in  1  0 = emit pixel 0 first; 1 = emit pixel 3 first.
- load  in  NUM_LAYERS  per-layer load strobe, qualified by pix_en.
- gfx  in  NUM_LAYERS*4*DOT_W  per layer, 4 pixels; pixel k at [k*DOT_W +: DOT_W].
- attr_col  in  NUM_LAYERS*COL_W  per-layer tile colour, captured on load.
- attr_pri  in  NUM_LAYERS*PRI_W  per-layer tile priority, captured on load.
- cpu_we  in  1  register write strobe.
- cpu_addr  in  4  register select.
- cpu_data  in  8  write data.
- clut_addr  out  COL_W+DOT_W  {colour, dot} to palette PROM.
- clut_valid  out  1  clut_addr updated this cycle.
- PRO  out  PRI_W  winning priority, for the sprite mixer.
- win_layer  out  3  winning layer index; 7 = background.

Behaviour:
- Reset (synchronous, while rst=1):
  - All shifters empty; clut_addr=0, clut_valid=0, PRO=0, win_layer=7.
  - Registers take reset values: enable=8'hFF, bgcol=0, overrides cleared.
  - cpu_we is ignored while rst=1.
- Registers (one-cycle write, visible to the compositor the next cycle):
  - 0x0: layer enable, bit i.
  - 0x1: background colour [COL_W-1:0].
  - 0x2+i: bit7 = override enable, [PRI_W-1:0] = override priority for layer i.
  - Addresses outside this map are ignored.
- Serialiser per layer (cycles with pix_en=1 only):
  - On load: capture gfx/attr and set count=4. The current pixel is the first pixel of the new group in the same cycle (pixel 0, or pixel 3 if FLIP=1).
  - Otherwise, if count>0: advance to the next pixel and decrement count. Direction is ascending index, or descending if FLIP=1.
  - count=0 (underrun): the layer presents TRANSPARENT_DOT.
  - load concurrent with a non-empty shifter: load wins; remaining pixels are discarded.
  - FLIP is sampled at load and held for the group.
- Stage 1 (registered on pix_en): latch each layer's {dot, col, eff_pri}.
  - eff_pri = override enabled ? override priority : attr_pri.
  - opaque_i = (dot != TRANSPARENT_DOT) & enable[i] & ~LAYER_DISABLE_MASK[i].
- Stage 2 (registered on pix_en): winner = opaque layer with the highest eff_pri.
  - Ties go to the higher layer index.
  - If no layer is opaque: clut_addr={bgcol, TRANSPARENT_DOT}, PRO=0, win_layer=7.
- Latency: exactly 2 pix_en cycles from a pixel being current to its clut_addr. clut_valid is pix_en delayed 2 stages and cleared by reset.
- pix_en=0: all state holds; clut_valid=0.
- Reset mid-line: pipeline flushes; the first valid output is 2 pix_en cycles after the first load.

Decomposition:
- Package tilegen_pkg holds:
  - Localparams: CLUT_W = COL_W+DOT_W, WIN_BG = 3'd7.
  - Register addresses REG_ENABLE, REG_BGCOL, REG_PRI_BASE.
  - A function that extracts the layer-i field from a packed vector.
- One sub-module: tile_pixel_serialiser (4-pixel shifter plus count/underrun), instantiated NUM_LAYERS times in a generate loop. The compositor stays inline.

Test Plan:
- Reset, then pix_en held high, no loads -> clut_addr={8'h00,3'h7}, win_layer=7, PRO=0, clut_valid=1 from the 3rd cycle.
- Layer 0 loaded with pixels {1,2,3,4}, col=8'h12, pri=2, FLIP=0 -> clut_addr 0x091,0x092,0x093,0x094 on 4 consecutive cycles starting 2 cycles after load; background thereafter. Repeat with FLIP=1 -> order 4,3,2,1.
- Layers 1 and 3 opaque, pri 5 and 5 -> layer 3 wins. Write 0x3=8'h86 (layer 1 override pri 6) -> layer 1 wins from the next pixel.
- Write 0x0=8'hF7 (layer 3 disabled) with layer 3 the only opaque layer -> background output. Write 0x1=8'hA5 -> clut_addr={8'hA5,3'h7}.
- Reload layer 2 after 2 pixels -> output pixels p0,p1,q0,q1,q2,q3 with no gap. Toggle pix_en low for 3 cycles -> outputs hold and clut_valid=0.
- Assert rst for 1 cycle mid-group with cpu_we=1 -> outputs reset, write discarded, enable reads back as 8'hFF behaviour.
